// File: rtl/inv_park_clarke_water.sv
// Inverse Park + inverse Clarke: (Vd, Vq, cos, sin) -> single-precision Va/Vb/Vc, fixed latency.
// Optional zero-sequence injection (V0 added to all phases) when INV_PARK_ZERO_SEQ_EN is defined.
module inv_park_clarke_water #(
  parameter int          MUL_LAT   = 5,
  parameter int          ADD_LAT   = 7,
  parameter logic [31:0] C_SQRT3_2 = 32'h3F5DB3D7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rst_user,
  input  logic        sta,
  input  logic [31:0] Vd,
  input  logic [31:0] Vq,
  input  logic [31:0] cos,
  input  logic [31:0] sin,
`ifdef INV_PARK_ZERO_SEQ_EN
  input  logic [31:0] V0,
`endif
  output logic [31:0] Va,
  output logic [31:0] Vb,
  output logic [31:0] Vc,
  output logic        done_sig
);

  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam int MA = MUL_LAT + ADD_LAT;
`ifdef INV_PARK_ZERO_SEQ_EN
  localparam int LAT = 2 * MA + ADD_LAT + 1;
`else
  localparam int LAT = 2 * MA + 1;
`endif

  // Denormal inputs are treated as zero; results round to nearest even and flush underflow to zero.
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic        sr;
    logic [47:0] p;
    logic [22:0] m;
    logic        g, st;
    logic [23:0] rnd;
    int          er;
    sr = a[31] ^ b[31];
    if ((a[30:23] == 8'hFF && a[22:0] != '0) || (b[30:23] == 8'hFF && b[22:0] != '0)) return QNAN;
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
      if (a[30:23] == '0 || b[30:23] == '0) return QNAN;
      return {sr, 8'hFF, 23'h0};
    end
    if (a[30:23] == '0 || b[30:23] == '0) return {sr, 31'h0};
    p  = {24'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:0]};
    er = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      m = p[46:24]; g = p[23]; st = |p[22:0]; er = er + 1;
    end else begin
      m = p[45:23]; g = p[22]; st = |p[21:0];
    end
    rnd = {1'b0, m} + 24'(g & (st | m[0]));
    if (rnd[23]) er = er + 1;
    if (er >= 255) return {sr, 8'hFF, 23'h0};
    if (er <= 0) return {sr, 31'h0};
    return {sr, 8'(er), rnd[22:0]};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y;
    logic [7:0]  d;
    logic [26:0] mx, my;
    logic [27:0] sum;
    logic [23:0] rnd;
    logic [4:0]  lz;
    logic        found;
    int          er;
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
      if ((a[30:23] == 8'hFF && a[22:0] != '0) || (b[30:23] == 8'hFF && b[22:0] != '0) ||
          (a[30:23] == 8'hFF && b[30:23] == 8'hFF && a[31] != b[31])) return QNAN;
      return (a[30:23] == 8'hFF) ? a : b;
    end
    if (a[30:23] == '0 && b[30:23] == '0) return {a[31] & b[31], 31'h0};
    if (a[30:23] == '0) return b;
    if (b[30:23] == '0) return a;
    if (b[30:0] > a[30:0]) begin
      x = b; y = a;
    end else begin
      x = a; y = b;
    end
    d  = x[30:23] - y[30:23];
    mx = {1'b1, x[22:0], 3'b000};
    my = {1'b1, y[22:0], 3'b000};
    // Bits shifted out of the smaller operand collapse into the sticky LSB.
    if (d > 8'd26) my = 27'd1;
    else my = (my >> d) | 27'((my & ((27'd1 << d) - 27'd1)) != '0);
    er = int'(x[30:23]);
    if (x[31] == y[31]) begin
      sum = {1'b0, mx} + {1'b0, my};
      if (sum[27]) begin
        sum = {1'b0, sum[27:2], sum[1] | sum[0]};
        er  = er + 1;
      end
    end else begin
      sum = {1'b0, mx} - {1'b0, my};
      if (sum == '0) return 32'h0;
      lz    = '0;
      found = 1'b0;
      for (int i = 26; i >= 0; i--) begin
        if (!found && sum[i]) begin
          lz    = 5'(26 - i);
          found = 1'b1;
        end
      end
      sum = sum << lz;
      er  = er - int'(lz);
    end
    rnd = {1'b0, sum[25:3]} + 24'(sum[2] & (sum[3] | sum[1] | sum[0]));
    if (rnd[23]) er = er + 1;
    if (er >= 255) return {x[31], 8'hFF, 23'h0};
    if (er <= 0) return {x[31], 31'h0};
    return {x[31], 8'(er), rnd[22:0]};
  endfunction

  // -x/2 by exponent decrement; exponent 1 would become denormal, so it flushes to signed zero.
  function automatic logic [31:0] neg_half(input logic [31:0] x);
    if (x[30:23] == 8'hFF) return {~x[31], x[30:0]};
    if (x[30:23] <= 8'd1) return {~x[31], 31'h0};
    return {~x[31], x[30:23] - 8'd1, x[22:0]};
  endfunction

  logic [31:0] p_dc_q [MUL_LAT];
  logic [31:0] p_qs_q [MUL_LAT];
  logic [31:0] p_ds_q [MUL_LAT];
  logic [31:0] p_qc_q [MUL_LAT];
  logic [31:0] alpha_q [ADD_LAT];
  logic [31:0] beta_q [ADD_LAT];
  logic [31:0] cb_q [MUL_LAT];
  logic [31:0] nh_q [MUL_LAT];
  logic [31:0] va_dly_q [MA];
  logic [31:0] vb_q [ADD_LAT];
  logic [31:0] vc_q [ADD_LAT];

  logic [31:0] dc, qs, ds, qc, alpha, beta, cb, nh;
  logic [31:0] res_a, res_b, res_c;

  assign dc    = p_dc_q[MUL_LAT-1];
  assign qs    = p_qs_q[MUL_LAT-1];
  assign ds    = p_ds_q[MUL_LAT-1];
  assign qc    = p_qc_q[MUL_LAT-1];
  assign alpha = alpha_q[ADD_LAT-1];
  assign beta  = beta_q[ADD_LAT-1];
  assign cb    = cb_q[MUL_LAT-1];
  assign nh    = nh_q[MUL_LAT-1];

  // Arithmetic pipeline: free-running, cleared only by the asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MUL_LAT; i++) begin
        p_dc_q[i] <= '0;
        p_qs_q[i] <= '0;
        p_ds_q[i] <= '0;
        p_qc_q[i] <= '0;
        cb_q[i]   <= '0;
        nh_q[i]   <= '0;
      end
      for (int i = 0; i < ADD_LAT; i++) begin
        alpha_q[i] <= '0;
        beta_q[i]  <= '0;
        vb_q[i]    <= '0;
        vc_q[i]    <= '0;
      end
      for (int i = 0; i < MA; i++) va_dly_q[i] <= '0;
    end else begin
      p_dc_q[0]   <= fp_mul(Vd, cos);
      p_qs_q[0]   <= fp_mul(Vq, sin);
      p_ds_q[0]   <= fp_mul(Vd, sin);
      p_qc_q[0]   <= fp_mul(Vq, cos);
      alpha_q[0]  <= fp_add(dc, {~qs[31], qs[30:0]});
      beta_q[0]   <= fp_add(ds, qc);
      cb_q[0]     <= fp_mul(beta, C_SQRT3_2);
      nh_q[0]     <= neg_half(alpha);
      va_dly_q[0] <= alpha;
      vb_q[0]     <= fp_add(nh, cb);
      vc_q[0]     <= fp_add(nh, {~cb[31], cb[30:0]});
      for (int i = 1; i < MUL_LAT; i++) begin
        p_dc_q[i] <= p_dc_q[i-1];
        p_qs_q[i] <= p_qs_q[i-1];
        p_ds_q[i] <= p_ds_q[i-1];
        p_qc_q[i] <= p_qc_q[i-1];
        cb_q[i]   <= cb_q[i-1];
        nh_q[i]   <= nh_q[i-1];
      end
      for (int i = 1; i < ADD_LAT; i++) begin
        alpha_q[i] <= alpha_q[i-1];
        beta_q[i]  <= beta_q[i-1];
        vb_q[i]    <= vb_q[i-1];
        vc_q[i]    <= vc_q[i-1];
      end
      for (int i = 1; i < MA; i++) va_dly_q[i] <= va_dly_q[i-1];
    end
  end

`ifdef INV_PARK_ZERO_SEQ_EN
  logic [31:0] v0_dly_q [2*MA];
  logic [31:0] za_q [ADD_LAT];
  logic [31:0] zb_q [ADD_LAT];
  logic [31:0] zc_q [ADD_LAT];
  logic [31:0] v0_al;

  assign v0_al = v0_dly_q[2*MA-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2 * MA; i++) v0_dly_q[i] <= '0;
      for (int i = 0; i < ADD_LAT; i++) begin
        za_q[i] <= '0;
        zb_q[i] <= '0;
        zc_q[i] <= '0;
      end
    end else begin
      v0_dly_q[0] <= V0;
      za_q[0]     <= fp_add(va_dly_q[MA-1], v0_al);
      zb_q[0]     <= fp_add(vb_q[ADD_LAT-1], v0_al);
      zc_q[0]     <= fp_add(vc_q[ADD_LAT-1], v0_al);
      for (int i = 1; i < 2 * MA; i++) v0_dly_q[i] <= v0_dly_q[i-1];
      for (int i = 1; i < ADD_LAT; i++) begin
        za_q[i] <= za_q[i-1];
        zb_q[i] <= zb_q[i-1];
        zc_q[i] <= zc_q[i-1];
      end
    end
  end

  assign res_a = za_q[ADD_LAT-1];
  assign res_b = zb_q[ADD_LAT-1];
  assign res_c = zc_q[ADD_LAT-1];
`else
  assign res_a = va_dly_q[MA-1];
  assign res_b = vb_q[ADD_LAT-1];
  assign res_c = vc_q[ADD_LAT-1];
`endif

  logic [LAT-1:0] vld_q, vld_d;
  logic [31:0]    va_q, va_d, vb_q_o, vb_d, vc_q_o, vc_d;

  // vld_q[LAT-2] marks the cycle the final stage holds this sample's result.
  assign vld_d = {vld_q[LAT-2:0], sta};
  assign va_d  = vld_q[LAT-2] ? res_a : va_q;
  assign vb_d  = vld_q[LAT-2] ? res_b : vb_q_o;
  assign vc_d  = vld_q[LAT-2] ? res_c : vc_q_o;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q  <= '0;
      va_q   <= '0;
      vb_q_o <= '0;
      vc_q_o <= '0;
    end else if (rst_user) begin
      vld_q  <= '0;
      va_q   <= '0;
      vb_q_o <= '0;
      vc_q_o <= '0;
    end else begin
      vld_q  <= vld_d;
      va_q   <= va_d;
      vb_q_o <= vb_d;
      vc_q_o <= vc_d;
    end
  end

  assign Va       = va_q;
  assign Vb       = vb_q_o;
  assign Vc       = vc_q_o;
  assign done_sig = vld_q[LAT-1];

endmodule

// File: tb/tb_inv_park_clarke_water.sv
// Directed bench for inv_park_clarke_water: vector table, burst, reset and user-clear sequences.
module tb_inv_park_clarke_water;
`ifdef INV_PARK_ZERO_SEQ_EN
  localparam int L = 32;
`else
  localparam int L = 25;
`endif
  localparam logic [31:0] NZ = 32'h80000000;

  logic        clk = 1'b0;
  logic        rst, rst_user, sta;
  logic [31:0] vd, vq, cs, sn;
`ifdef INV_PARK_ZERO_SEQ_EN
  logic [31:0] v0;
`endif
  logic [31:0] va, vb, vc;
  logic        done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inv_park_clarke_water dut (
    .clk(clk), .rst(rst), .rst_user(rst_user), .sta(sta),
    .Vd(vd), .Vq(vq), .cos(cs), .sin(sn),
`ifdef INV_PARK_ZERO_SEQ_EN
    .V0(v0),
`endif
    .Va(va), .Vb(vb), .Vc(vc), .done_sig(done)
  );

  typedef struct packed {
    logic [31:0] vd, vq, cs, sn, v0, ea, eb, ec;
    logic [2:0]  mag;  // compare magnitude only (sign of zero is don't-care) for a/b/c
  } vec_t;

  function automatic vec_t mk(input logic [31:0] d, q, c, s, z, ea, eb, ec, input logic [2:0] m);
    vec_t v;
    v.vd = d; v.vq = q; v.cs = c; v.sn = s; v.v0 = z;
    v.ea = ea; v.eb = eb; v.ec = ec; v.mag = m;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp, input logic mag);
    checks++;
    if (mag ? (act[30:0] !== exp[30:0]) : (act !== exp)) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input logic s);
    vd = v.vd; vq = v.vq; cs = v.cs; sn = v.sn;
`ifdef INV_PARK_ZERO_SEQ_EN
    v0 = v.v0;
`endif
    sta = s;
  endtask

  task automatic scramble();
    vd = $urandom; vq = $urandom; cs = $urandom; sn = $urandom;
`ifdef INV_PARK_ZERO_SEQ_EN
    v0 = $urandom;
`endif
    sta = 1'b0;
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    int lat;
    @(negedge clk);
    drive(v, 1'b1);
    @(negedge clk);
    scramble();
    lat = 1;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, "_latency"}, 32'(lat), 32'(L), 1'b0);
    chk({nm, "_va"}, va, v.ea, v.mag[0]);
    chk({nm, "_vb"}, vb, v.eb, v.mag[1]);
    chk({nm, "_vc"}, vc, v.ec, v.mag[2]);
    @(negedge clk);
    chk({nm, "_done_pulse"}, 32'(done), 32'd0, 1'b0);
    chk({nm, "_va_hold"}, va, v.ea, v.mag[0]);
  endtask

  task automatic expect_quiet(input string nm, input int ncyc);
    int n = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (done) n++;
    end
    chk(nm, 32'(n), 32'd0, 1'b0);
  endtask

  vec_t vecs[$];
  logic [31:0] burst_a [10] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                                32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000, 32'h41200000};
  logic [31:0] burst_b [10] = '{32'hBF000000, 32'hBF800000, 32'hBFC00000, 32'hC0000000, 32'hC0200000,
                                32'hC0400000, 32'hC0600000, 32'hC0800000, 32'hC0900000, 32'hC0A00000};

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b0; rst_user = 1'b0; sta = 1'b0;
    vd = '0; vq = '0; cs = '0; sn = '0;
`ifdef INV_PARK_ZERO_SEQ_EN
    v0 = '0;
`endif
    vecs.push_back(mk(32'h3F800000, 0, 32'h3F800000, 0, NZ, 32'h3F800000, 32'hBF000000, 32'hBF000000, 3'b000));
    vecs.push_back(mk(0, 32'h3F800000, 32'h3F800000, 0, NZ, 32'h0, 32'h3F5DB3D7, 32'hBF5DB3D7, 3'b001));
    vecs.push_back(mk(0, 0, 32'h3F800000, 0, NZ, 32'h0, 32'h0, 32'h0, 3'b111));
    vecs.push_back(mk(32'h40000000, 0, 0, 32'h3F800000, NZ, 32'h0, 32'h3FDDB3D7, 32'hBFDDB3D7, 3'b001));
    vecs.push_back(mk(32'h3F800000, 32'h3F800000, 32'h3F800000, 0, NZ, 32'h3F800000, 32'h3EBB67AE, 32'hBFAED9EC, 3'b000));
    vecs.push_back(mk(32'hBF800000, 0, 32'h3F800000, 0, NZ, 32'hBF800000, 32'h3F000000, 32'h3F000000, 3'b000));
    vecs.push_back(mk(0, 32'h3F800000, 0, 32'hBF800000, NZ, 32'h3F800000, 32'hBF000000, 32'hBF000000, 3'b000));
    vecs.push_back(mk(32'h00800000, 0, 32'h3F800000, 0, NZ, 32'h00800000, 32'h00000000, 32'h80000000, 3'b000));
    vecs.push_back(mk(32'h01000000, 0, 32'h3F800000, 0, NZ, 32'h01000000, 32'h80800000, 32'h80800000, 3'b000));
`ifdef INV_PARK_ZERO_SEQ_EN
    vecs.push_back(mk(32'h3F800000, 0, 32'h3F800000, 0, 32'h3E800000, 32'h3FA00000, 32'hBE800000, 32'hBE800000, 3'b000));
`endif

    repeat (3) @(negedge clk);
    chk("reset_va", va, 32'h0, 1'b0);
    chk("reset_vb", vb, 32'h0, 1'b0);
    chk("reset_vc", vc, 32'h0, 1'b0);
    chk("reset_done", 32'(done), 32'd0, 1'b0);
    rst = 1'b1;

    foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Back-to-back samples, one per clock.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      drive(mk(burst_a[k], 0, 32'h3F800000, 0, NZ, 0, 0, 0, 3'b000), 1'b1);
    end
    @(negedge clk);
    scramble();
    n = 10;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("burst_latency", 32'(n), 32'(L), 1'b0);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("burst%0d_done", k), 32'(done), 32'd1, 1'b0);
      chk($sformatf("burst%0d_va", k), va, burst_a[k], 1'b0);
      chk($sformatf("burst%0d_vb", k), vb, burst_b[k], 1'b0);
      @(negedge clk);
    end
    chk("burst_end_done", 32'(done), 32'd0, 1'b0);

    // Asynchronous reset in the middle of a 3-sample burst.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(vecs[4], 1'b1);
    end
    for (int k = 3; k <= 10; k++) begin
      @(negedge clk);
      scramble();
    end
    rst = 1'b0;
    #1;
    chk("arst_va", va, 32'h0, 1'b0);
    chk("arst_vb", vb, 32'h0, 1'b0);
    chk("arst_vc", vc, 32'h0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    expect_quiet("arst_no_done", L + 10);
    run_vec("arst_recover", vecs[0]);

    // Synchronous user clear while a sample is in flight.
    @(negedge clk);
    drive(vecs[5], 1'b1);
    repeat (5) begin
      @(negedge clk);
      scramble();
    end
    rst_user = 1'b1;
    @(negedge clk);
    rst_user = 1'b0;
    chk("uclr_va", va, 32'h0, 1'b0);
    chk("uclr_vb", vb, 32'h0, 1'b0);
    chk("uclr_vc", vc, 32'h0, 1'b0);
    expect_quiet("uclr_no_done", L + 10);

    // sta coinciding with rst_user is discarded.
    @(negedge clk);
    drive(vecs[0], 1'b1);
    rst_user = 1'b1;
    @(negedge clk);
    scramble();
    rst_user = 1'b0;
    expect_quiet("uclr_sta_dropped", L + 10);
    run_vec("uclr_recover", vecs[6]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
